// File: rtl/cen_gen_frac.sv
// Multi-channel fractional clock-enable generator: after a fixed settle period each
// channel emits MUL/DIV pulses per clock using a phase accumulator, with pause and resync.
module cen_gen_frac #(
    parameter int                            CHANNELS    = 2,
    parameter int                            ACC_WIDTH   = 16,
    parameter logic [CHANNELS*ACC_WIDTH-1:0] MUL         = {16'd1, 16'd1},
    parameter logic [CHANNELS*ACC_WIDTH-1:0] DIV         = {16'd2, 16'd16},
    parameter logic [CHANNELS*ACC_WIDTH-1:0] PHASE       = {16'd0, 16'd0},
    parameter int                            LOCK_CYCLES = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                pause,
    input  logic                resync,
    output logic                locked,
    output logic [CHANNELS-1:0] cen
);

    localparam int CNT_W = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_CYCLES - 1);

    typedef enum logic {
        SETTLE = 1'b0,
        RUN    = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             locked_q, locked_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= SETTLE;
            cnt_q    <= '0;
            locked_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            locked_q <= locked_d;
        end
    end

    // The counter stops once RUN is reached; only rst brings it back to zero.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        locked_d = locked_q;
        case (state_q)
            SETTLE: begin
                if (cnt_q == CNT_LAST) begin
                    state_d  = RUN;
                    locked_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RUN: begin
                locked_d = 1'b1;
            end
            default: begin
                state_d = SETTLE;
            end
        endcase
    end

    assign locked = locked_q;

    genvar gi;
    generate
        for (gi = 0; gi < CHANNELS; gi++) begin : g_chan
            localparam logic [ACC_WIDTH-1:0] MUL_W   = MUL[gi*ACC_WIDTH +: ACC_WIDTH];
            localparam logic [ACC_WIDTH-1:0] DIV_W   = DIV[gi*ACC_WIDTH +: ACC_WIDTH];
            localparam logic [ACC_WIDTH-1:0] PHASE_W = PHASE[gi*ACC_WIDTH +: ACC_WIDTH];

            logic [ACC_WIDTH-1:0] acc_q, acc_d;
            logic                 cen_q, cen_d;
            logic [ACC_WIDTH:0]   sum;

            // One extra bit so acc + MUL can never wrap before the DIV compare.
            assign sum = {1'b0, acc_q} + {1'b0, MUL_W};

            always_comb begin
                acc_d = acc_q;
                cen_d = 1'b0;
                if (state_q == RUN) begin
                    if (resync) begin
                        acc_d = PHASE_W;
                    end else if (!pause) begin
                        if (sum >= {1'b0, DIV_W}) begin
                            // Result is below DIV so modulo-width arithmetic is exact.
                            acc_d = acc_q + MUL_W - DIV_W;
                            cen_d = 1'b1;
                        end else begin
                            acc_d = acc_q + MUL_W;
                        end
                    end
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    acc_q <= PHASE_W;
                    cen_q <= 1'b0;
                end else begin
                    acc_q <= acc_d;
                    cen_q <= cen_d;
                end
            end

            assign cen[gi] = cen_q;
        end
    endgenerate

endmodule

// File: tb/tb_cen_gen_frac.sv
// Bench for cen_gen_frac: directed scenarios plus random pause/resync/reset traffic,
// checked each cycle against a closed-form pulse-count model.
module tb_cen_gen_frac;

    localparam int CH = 6;
    localparam int AW = 16;
    localparam int LC = 16;
    localparam logic [CH*AW-1:0] P_MUL = {16'd5, 16'd1, 16'd1, 16'd3, 16'd1, 16'd1};
    localparam logic [CH*AW-1:0] P_DIV = {16'd5, 16'd4, 16'd4, 16'd8, 16'd16, 16'd2};
    localparam logic [CH*AW-1:0] P_PH  = {16'd0, 16'd2, 16'd0, 16'd0, 16'd0, 16'd0};

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          pause = 1'b0;
    logic          resync = 1'b0;
    logic          locked;
    logic [CH-1:0] cen;

    int checks = 0;
    int errors = 0;

    cen_gen_frac #(
        .CHANNELS   (CH),
        .ACC_WIDTH  (AW),
        .MUL        (P_MUL),
        .DIV        (P_DIV),
        .PHASE      (P_PH),
        .LOCK_CYCLES(LC)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .pause (pause),
        .resync(resync),
        .locked(locked),
        .cen   (cen)
    );

    always #5 clk = ~clk;

    // Reference model: a channel that has taken n accumulation steps since its
    // last (re)start has emitted floor((PHASE + n*MUL)/DIV) pulses in total.
    int            m_cnt;
    bit            m_run;
    longint        m_n[CH];
    logic          exp_locked;
    logic [CH-1:0] exp_cen;
    int            pulses[CH];

    function automatic longint fld(input logic [CH*AW-1:0] v, input int c);
        logic [AW-1:0] f;
        f = v[c*AW +: AW];
        return longint'(f);
    endfunction

    function automatic longint total(input int c, input longint n);
        return (fld(P_PH, c) + n * fld(P_MUL, c)) / fld(P_DIV, c);
    endfunction

    task automatic model_edge(input logic r, input logic rs, input logic pa);
        if (r) begin
            m_cnt = 0;
            m_run = 1'b0;
            exp_locked = 1'b0;
            exp_cen = '0;
            for (int c = 0; c < CH; c++) m_n[c] = 0;
        end else if (!m_run) begin
            m_cnt++;
            exp_cen = '0;
            if (m_cnt == LC) begin
                m_run = 1'b1;
                exp_locked = 1'b1;
            end
        end else begin
            for (int c = 0; c < CH; c++) begin
                if (rs) begin
                    m_n[c] = 0;
                    exp_cen[c] = 1'b0;
                end else if (pa) begin
                    exp_cen[c] = 1'b0;
                end else begin
                    m_n[c]++;
                    exp_cen[c] = (total(c, m_n[c]) > total(c, m_n[c] - 1));
                end
            end
        end
    endtask

    task automatic step(input logic r, input logic rs, input logic pa);
        rst = r;
        resync = rs;
        pause = pa;
        @(posedge clk);
        model_edge(r, rs, pa);
        #1;
        checks++;
        assert (locked === exp_locked) else begin
            errors++;
            $error("FAIL locked t=%0t rst=%b rs=%b pa=%b got %b exp %b", $time, r, rs, pa, locked, exp_locked);
        end
        checks++;
        assert (cen === exp_cen) else begin
            errors++;
            $error("FAIL cen t=%0t rst=%b rs=%b pa=%b got %b exp %b", $time, r, rs, pa, cen, exp_cen);
        end
        for (int c = 0; c < CH; c++) if (cen[c] === 1'b1) pulses[c]++;
        $display("cyc t=%0t rst=%b rs=%b pa=%b locked=%b cen=%b", $time, r, rs, pa, locked, cen);
    endtask

    task automatic clear_pulses();
        for (int c = 0; c < CH; c++) pulses[c] = 0;
    endtask

    task automatic check_count(input int c, input int expv);
        checks++;
        assert (pulses[c] === expv) else begin
            errors++;
            $error("FAIL count ch%0d got %0d exp %0d", c, pulses[c], expv);
        end
    endtask

    initial begin
        m_cnt = 0;
        m_run = 1'b0;
        exp_locked = 1'b0;
        exp_cen = '0;
        for (int c = 0; c < CH; c++) m_n[c] = 0;
        clear_pulses();

        // Reset, then settle: locked must rise on exactly the 16th edge.
        repeat (3) step(1'b1, 1'b0, 1'b0);
        repeat (LC) step(1'b0, 1'b0, 1'b0);
        checks++;
        assert (locked === 1'b1) else begin
            errors++;
            $error("FAIL lock_edge got %b exp 1", locked);
        end

        // Free run of 800 RUN cycles.
        clear_pulses();
        repeat (800) step(1'b0, 1'b0, 1'b0);
        check_count(0, 400);
        check_count(1, 50);
        check_count(2, 300);
        check_count(3, 200);
        check_count(4, 200);
        check_count(5, 800);

        // Resync, then 805 cycles with a 5-cycle pause in the middle.
        step(1'b0, 1'b1, 1'b0);
        clear_pulses();
        repeat (400) step(1'b0, 1'b0, 1'b0);
        repeat (5) step(1'b0, 1'b0, 1'b1);
        repeat (400) step(1'b0, 1'b0, 1'b0);
        check_count(2, 300);
        check_count(1, 50);

        // Reset during RUN, then during SETTLE with pause/resync ignored.
        step(1'b1, 1'b0, 1'b0);
        repeat (5) step(1'b0, 1'b1, 1'b1);
        step(1'b1, 1'b0, 1'b0);
        repeat (LC) step(1'b0, 1'b0, 1'b1);
        repeat (20) step(1'b0, 1'b0, 1'b0);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            step(logic'($urandom_range(0, 199) == 0),
                 logic'($urandom_range(0, 49) == 0),
                 logic'($urandom_range(0, 9) < 2));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cen_gen_frac.md
Name: cen_gen_frac

Overview:
- Parametrised multi-channel fractional clock-enable generator. It runs in the 96 MHz system clock domain produced by the core PLL.
- It derives N independent clock-enable pulse trains, with per-channel rational ratio and phase offset, from the single fast clock.
- It has a PLL-style lock/settle sequence, pause freeze and phase resync. It replaces ad-hoc divider counters feeding the CPU, sound and video timing.

Parameters:
- CHANNELS, 2, number of enable outputs (1..8).
- ACC_WIDTH, 16, accumulator width per channel.
- MUL, {16'd1,16'd1}, packed CHANNELS*ACC_WIDTH numerators; channel i occupies bits [i*ACC_WIDTH +: ACC_WIDTH].
- DIV, {16'd2,16'd16}, packed denominators, same layout. Constraints: DIV>0 and MUL<=DIV.
- PHASE, {16'd0,16'd0}, packed initial accumulator values. Constraint: PHASE<DIV.
- LOCK_CYCLES, 16, settle cycles after reset before enables start (>=1).

Ports:
- clk  in  1  system clock (96 MHz).
- rst  in  1  synchronous active-high reset.
- pause  in  1  freeze all accumulators, suppress enables.
- resync  in  1  reload all accumulators to PHASE on this cycle.
- locked  out  1  high once the settle period is complete.
- cen  out  CHANNELS  per-channel one-cycle enable pulses, registered.

Behaviour:
- One clock (clk); reset is synchronous and active-high (rst), sampled on the rising edge of clk.
- Reset values: locked=0, cen=0, lock counter=0, acc[i]=PHASE[i], state=SETTLE.
- States:
  - SETTLE: lock counter increments each cycle; cen held 0; accumulators held at PHASE. When the counter equals LOCK_CYCLES-1, go to RUN and set locked=1 on that edge. locked first reads high LOCK_CYCLES edges after the first edge with rst=0.
  - RUN: locked stays 1 until rst. Only rst leaves RUN.
- Per channel in RUN with pause=0, resync=0:
  - sum = acc + MUL, computed at ACC_WIDTH+1 bits, no overflow possible.
  - If sum >= DIV: acc <= sum - DIV and cen[i] <= 1.
  - Else: acc <= sum and cen[i] <= 0.
- Latency: cen is a register output. A pulse is high for exactly one cycle, on the edge following the accumulation that crossed DIV.
- Long-run average rate: MUL/DIV pulses per clk. Pulses never occur on consecutive cycles unless MUL*2>DIV. MUL==DIV gives cen constantly high.
- pause=1 in RUN: accumulators hold, cen<=0. On release, the sequence resumes exactly where it stopped, with no lost or extra pulses.
- resync=1 in RUN: acc[i]<=PHASE[i] for all channels, cen<=0 that cycle. Accumulation restarts on the next cycle.
- Priority: rst > resync > pause > accumulate.
- resync or pause during SETTLE: ignored; the counter keeps running.
- Reset mid-operation (any state): all state returns to reset values on that edge, cen drops to 0 on that edge, and locked drops to 0.
- Channels are fully independent; all update on the same edge.
- Inputs pause/resync are synchronous to clk; no internal synchronisers.

Test Plan:
- Reset release, LOCK_CYCLES=16, CH0 MUL=1/DIV=2 -> locked=0 and cen=0 for 15 edges, locked=1 on edge 16. cen[0] pulses on RUN cycles 2,4,6,...
- CH1 MUL=1/DIV=16 over 160 RUN cycles -> exactly 10 pulses, spaced 16 cycles, each one cycle wide (96 MHz -> 6 MHz).
- Fractional MUL=3/DIV=8, PHASE=0 -> pulses on RUN cycles 3,6,8, repeating every 8. Exactly 300 pulses in 800 cycles.
- Phase offset: two channels MUL=1/DIV=4, PHASE=0 and PHASE=2 -> pulses offset by 2 cycles. resync mid-run restores the same relative alignment and gives cen=0 on the resync cycle.
- pause held 5 cycles mid-run with MUL=3/DIV=8 -> cen=0 throughout. After release, the pulse pattern continues from the frozen accumulator value, and the total pulse count equals the unpaused run shifted by 5 cycles.
- rst asserted during RUN and during SETTLE -> locked=0 and cen=0 on the next edge. The full LOCK_CYCLES settle repeats, and accumulators restart from PHASE.
